div_req_sequencer: RTL and testbench

- Initiator side of the divider start/result handshake.
- Accepts (dividend, divisor) pairs on a valid/ready stream and drives the divider's `start`, `dividend_data` and `divisor_data`.
- Waits for `result_valid`, then merges the split {quotient, signed fraction} result into one two's-complement Q32.15 word on a valid/ready output stream.
- Handles divide-by-zero locally and aborts on divider timeout; it feeds the pseudo-inverse datapath.

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_result_merge.sv | 24 ++
 rtl/div_req_sequencer.sv | 168 ++++++++++++++++
 tb/tb_div_req_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider handshake: FSM states, widths, result
// field slices and divide-by-zero saturation constants.
package div_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;
  localparam int Q_FRAC = 15;
  localparam int RES_W  = DATA_W + FRAC_W;

  // divider result layout: {quotient[Q_MSB:Q_LSB], fraction[F_MSB:F_LSB]}
  localparam int Q_MSB = RES_W - 1;
  localparam int Q_LSB = FRAC_W;
  localparam int F_MSB = FRAC_W - 1;
  localparam int F_LSB = 0;

  localparam logic [RES_W-1:0] SAT_POS = {1'b0, {(RES_W-1){1'b1}}};
  localparam logic [RES_W-1:0] SAT_NEG = {1'b1, {(RES_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } div_state_e;

  function automatic logic [RES_W-1:0] div0_sat(input logic [DATA_W-1:0] dividend);
    if (dividend == '0) return '0;
    if (dividend[DATA_W-1]) return SAT_NEG;
    return SAT_POS;
  endfunction

endpackage

// File: rtl/div_result_merge.sv
// Merges the divider's {quotient, signed fraction} into one Q32.15 word, or
// selects the divide-by-zero saturation value for the given dividend.
module div_result_merge
  import div_pkg::*;
(
  input  logic [RES_W-1:0]  result,
  input  logic [DATA_W-1:0] dividend,
  input  logic              sat_sel,
  output logic [RES_W-1:0]  merged
);

  logic [RES_W-1:0] q_ext;
  logic [RES_W-1:0] f_ext;

  // fraction carries the quotient's sign, so a plain 48-bit add is exact
  assign q_ext = {result[Q_MSB], result[Q_MSB:Q_LSB], {Q_FRAC{1'b0}}};
  assign f_ext = {{(RES_W-FRAC_W){result[F_MSB]}}, result[F_MSB:F_LSB]};

  always_comb begin
    merged = q_ext + f_ext;
    if (sat_sel) merged = div0_sat(dividend);
  end

endmodule

// File: rtl/div_req_sequencer.sv
// Divider initiator: issues start/operands, waits for a fresh result edge and
// returns a merged Q32.15 word. Statistics counters exist only with DIV_STATS_EN.
//
// state   | meaning
// IDLE    | ready for an operand pair
// ISSUE   | div_start pulse, operands stable
// WAIT    | waiting for a rising result_valid or timeout
// OUT     | result held on the output stream until taken
module div_req_sequencer #(
  parameter int DATA_W         = 32,
  parameter int FRAC_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_dividend,
  input  logic [DATA_W-1:0]        in_divisor,
  output logic                     div_start,
  output logic [DATA_W-1:0]        div_dividend,
  output logic [DATA_W-1:0]        div_divisor,
  input  logic [DATA_W+FRAC_W-1:0] div_result,
  input  logic                     div_result_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W+FRAC_W-1:0] out_data,
  output logic                     out_div0,
  output logic                     out_timeout,
  output logic [15:0]              cnt_ops,
  output logic [15:0]              cnt_div0,
  output logic [15:0]              cnt_tmo
);
  import div_pkg::*;

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  div_state_e state, state_nxt;

  logic                     rv_q;
  logic                     rv_rise;
  logic                     accept;
  logic                     load_sat;
  logic                     take_result;
  logic                     tmo_hit;
  logic                     out_done;
  logic [TMO_W-1:0]         tmo_cnt;
  logic [DATA_W+FRAC_W-1:0] merged;

  // only a fresh low-to-high transition counts; a level left high is stale
  assign rv_rise   = div_result_valid & ~rv_q;
  assign in_ready  = (state == S_IDLE) & ~rst;
  assign div_start = (state == S_ISSUE);
  assign out_valid = (state == S_OUT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    load_sat    = 1'b0;
    take_result = 1'b0;
    tmo_hit     = 1'b0;
    out_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (in_divisor == '0) begin
            load_sat  = 1'b1;
            state_nxt = S_OUT;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (rv_rise) begin
          take_result = 1'b1;
          state_nxt   = S_OUT;
        end else if (tmo_cnt == '0) begin
          tmo_hit   = 1'b1;
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  div_result_merge u_merge (
    .result   (div_result),
    .dividend (in_dividend),
    .sat_sel  (load_sat),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rv_q         <= 1'b0;
      tmo_cnt      <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      out_data     <= '0;
      out_div0     <= 1'b0;
      out_timeout  <= 1'b0;
    end else begin
      rv_q <= div_result_valid;
      if (accept) begin
        div_dividend <= in_dividend;
        div_divisor  <= in_divisor;
      end
      if (load_sat) begin
        out_data <= merged;
        out_div0 <= 1'b1;
      end
      if (state == S_ISSUE)
        tmo_cnt <= TMO_LOAD;
      else if (state == S_WAIT && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - 1'b1;
      if (take_result) out_data <= merged;
      if (tmo_hit) begin
        out_data    <= '0;
        out_timeout <= 1'b1;
      end
      if (out_done) begin
        out_data    <= '0;
        out_div0    <= 1'b0;
        out_timeout <= 1'b0;
      end
    end
  end

`ifdef DIV_STATS_EN
  logic [15:0] ops_q, div0_q, tmo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q  <= '0;
      div0_q <= '0;
      tmo_q  <= '0;
    end else if (out_done) begin
      if (ops_q != 16'hFFFF) ops_q <= ops_q + 16'd1;
      if (out_div0 && div0_q != 16'hFFFF) div0_q <= div0_q + 16'd1;
      if (out_timeout && tmo_q != 16'hFFFF) tmo_q <= tmo_q + 16'd1;
    end
  end

  assign cnt_ops  = ops_q;
  assign cnt_div0 = div0_q;
  assign cnt_tmo  = tmo_q;
`else
  assign cnt_ops  = '0;
  assign cnt_div0 = '0;
  assign cnt_tmo  = '0;
`endif

endmodule

// File: tb/tb_div_req_sequencer.sv
// Self-checking bench for div_req_sequencer: a transaction-level timeline model
// (arithmetic expectations, spec latencies) checked every cycle.
module tb_div_req_sequencer;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [47:0] div_result;
  logic        div_result_valid;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic        out_div0;
  logic        out_timeout;
  logic [15:0] cnt_ops;
  logic [15:0] cnt_div0;
  logic [15:0] cnt_tmo;

  int checks   = 0;
  int failures = 0;

  logic        chk_en;
  logic        exp_in_ready, exp_div_start, exp_out_valid, exp_div0, exp_tmo;
  logic [47:0] exp_data;
  logic [31:0] exp_a, exp_b;
  int          exp_ops, exp_d0, exp_to;

  always #5 clk = ~clk;

  div_req_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_dividend      (in_dividend),
    .in_divisor       (in_divisor),
    .div_start        (div_start),
    .div_dividend     (div_dividend),
    .div_divisor      (div_divisor),
    .div_result       (div_result),
    .div_result_valid (div_result_valid),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_div0         (out_div0),
    .out_timeout      (out_timeout),
    .cnt_ops          (cnt_ops),
    .cnt_div0         (cnt_div0),
    .cnt_tmo          (cnt_tmo)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endfunction

  // compare process: outputs sampled 1ns after each active edge
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(exp_in_ready));
      check("div_start", 64'(div_start), 64'(exp_div_start));
      check("out_valid", 64'(out_valid), 64'(exp_out_valid));
      check("out_div0", 64'(out_div0), 64'(exp_div0));
      check("out_timeout", 64'(out_timeout), 64'(exp_tmo));
      if (exp_out_valid) check("out_data", 64'(out_data), 64'(exp_data));
      if (exp_div_start) begin
        check("div_dividend", 64'(div_dividend), 64'(exp_a));
        check("div_divisor", 64'(div_divisor), 64'(exp_b));
      end
`ifdef DIV_STATS_EN
      check("cnt_ops", 64'(cnt_ops), 64'(exp_ops));
      check("cnt_div0", 64'(cnt_div0), 64'(exp_d0));
      check("cnt_tmo", 64'(cnt_tmo), 64'(exp_to));
`else
      check("cnt_ops", 64'(cnt_ops), 64'd0);
      check("cnt_div0", 64'(cnt_div0), 64'd0);
      check("cnt_tmo", 64'(cnt_tmo), 64'd0);
`endif
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    exp_in_ready  = 1'b1;
    exp_div_start = 1'b0;
    exp_out_valid = 1'b0;
    exp_div0      = 1'b0;
    exp_tmo       = 1'b0;
  endtask

  // one full operation; the bench plays the divider and predicts every cycle
  task automatic do_op(input logic signed [31:0] a, input logic signed [31:0] b,
                       input int lat, input bit respond, input int stale, input int bp,
                       input bit use_pin, input logic [47:0] pin);
    logic signed [63:0] la, lb, q, f, ev;
    la = a;
    lb = b;
    in_valid     = 1'b1;
    in_dividend  = a;
    in_divisor   = b;
    exp_in_ready = 1'b0;
    if (b == 0) begin
      exp_out_valid = 1'b1;
      exp_div0      = 1'b1;
      exp_data      = (a > 0) ? 48'h7FFF_FFFF_FFFF : (a < 0) ? 48'h8000_0000_0000 : 48'h0;
    end else begin
      exp_div_start = 1'b1;
      exp_a         = a;
      exp_b         = b;
    end
    step();
    in_valid    = 1'b0;
    in_dividend = $urandom();
    in_divisor  = $urandom();
    if (b != 0) begin
      exp_div_start = 1'b0;
      if (stale == 0) div_result_valid = 1'b0;
      step();
      if (respond) begin
        if (stale > 0) begin
          repeat (stale) step();
          div_result_valid = 1'b0;
          step();
        end
        repeat (lat - 1) step();
        q  = la / lb;
        f  = ((la % lb) * 32768) / lb;
        ev = (la * 32768) / lb;
        div_result       = {q[31:0], f[15:0]};
        div_result_valid = 1'b1;
        exp_out_valid    = 1'b1;
        exp_data         = ev[47:0];
      end else begin
        repeat (TMO - 1) step();
        exp_out_valid = 1'b1;
        exp_tmo       = 1'b1;
        exp_data      = '0;
      end
      step();
    end
    if (use_pin) check("out_data_literal", 64'(out_data), 64'(pin));
    repeat (bp) step();
    out_ready = 1'b1;
    if (exp_ops < 65535) exp_ops++;
    if (exp_div0 && exp_d0 < 65535) exp_d0++;
    if (exp_tmo && exp_to < 65535) exp_to++;
    set_idle();
    step();
    out_ready = 1'b0;
  endtask

  task automatic reset_mid_wait();
    in_valid      = 1'b1;
    in_dividend   = 32'd1000;
    in_divisor    = 32'd3;
    exp_in_ready  = 1'b0;
    exp_div_start = 1'b1;
    exp_a         = 32'd1000;
    exp_b         = 32'd3;
    step();
    in_valid         = 1'b0;
    exp_div_start    = 1'b0;
    div_result_valid = 1'b0;
    step();
    step();
    rst     = 1'b1;
    exp_ops = 0;
    exp_d0  = 0;
    exp_to  = 0;
    step();
    check("rst_div_dividend", 64'(div_dividend), 64'd0);
    check("rst_div_divisor", 64'(div_divisor), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    div_result       = {32'd333, 16'h5555};
    div_result_valid = 1'b1;
    rst              = 1'b0;
    exp_in_ready     = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    logic signed [31:0] ra, rb;
    int sel;
    rst = 1'b1; in_valid = 1'b0; in_dividend = '0; in_divisor = '0;
    div_result = '0; div_result_valid = 1'b0; out_ready = 1'b0;
    chk_en = 1'b0;
    set_idle();
    exp_in_ready = 1'b0;
    exp_data = '0; exp_a = '0; exp_b = '0;
    exp_ops = 0; exp_d0 = 0; exp_to = 0;
    step();
    chk_en = 1'b1;
    repeat (2) step();
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_div_dividend", 64'(div_dividend), 64'd0);
    check("reset_div_divisor", 64'(div_divisor), 64'd0);
    rst = 1'b0;
    exp_in_ready = 1'b1;
    step();

    do_op(100, 5, 3, 1'b1, 0, 0, 1'b1, 48'h0000_000A_0000);
    do_op(7, 3, 1, 1'b1, 0, 2, 1'b1, 48'h0000_0001_2AAA);
    do_op(-50, 4, 5, 1'b1, 0, 0, 1'b1, 48'hFFFF_FFF9_C000);
    do_op(9, 0, 1, 1'b1, 0, 0, 1'b1, 48'h7FFF_FFFF_FFFF);
    do_op(-9, 0, 1, 1'b1, 0, 1, 1'b1, 48'h8000_0000_0000);
    do_op(0, 0, 1, 1'b1, 0, 0, 1'b1, 48'h0);
    do_op(5, 2, 1, 1'b0, 0, 0, 1'b1, 48'h0);

    // stale high level left after the timeout must not complete the next op
    div_result       = 48'hDEAD_BEEF_1234;
    div_result_valid = 1'b1;
    repeat (3) step();
    do_op(7, 3, 2, 1'b1, 4, 0, 1'b1, 48'h0000_0001_2AAA);

    do_op(123456, -7, 4, 1'b1, 0, 5, 1'b0, 48'h0);
    reset_mid_wait();
    do_op(-1000, 7, 2, 1'b1, 0, 0, 1'b0, 48'h0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom();
      if (ra == 32'sh8000_0000) ra = 1;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 0;
      else if (sel < 4) rb = ($urandom_range(0, 1) == 1) ? -$urandom_range(1, 100) : $urandom_range(1, 100);
      else begin
        rb = $urandom();
        if (rb == 0) rb = 1;
      end
      do_op(ra, rb, $urandom_range(1, 12), ($urandom_range(0, 9) != 0),
            $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 48'h0);
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
